// File: rtl/gr_cordic_if.sv
// Handshake bundle for the Givens-rotation CORDIC engine: job request side
// (in_*, mode, operands, direction word) and result side (out_*, results).
interface gr_cordic_if #(
    parameter int R_LEN  = 12,
    parameter int N_ITER = 12
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     mode;
    logic                     nop;
    logic                     neg_i;
    logic [2*N_ITER-1:0]      dir_i;
    logic signed [R_LEN-1:0]  xi;
    logic signed [R_LEN-1:0]  yi;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [R_LEN-1:0]  xo;
    logic signed [R_LEN-1:0]  yo;
    logic [2*N_ITER-1:0]      dir_o;
    logic                     neg_o;

    modport master (
        output in_valid, mode, nop, neg_i, dir_i, xi, yi, out_ready,
        input  in_ready, out_valid, xo, yo, dir_o, neg_o
    );

    modport slave (
        input  in_valid, mode, nop, neg_i, dir_i, xi, yi, out_ready,
        output in_ready, out_valid, xo, yo, dir_o, neg_o
    );
endinterface

// File: rtl/gr_cordic_engine.sv
// Multi-cycle Givens-rotation CORDIC: ITER_PER_CYC unrolled micro-rotations per clock.
// Optional GR_SCALE_COMP_EN adds a gain-compensation SCALE state after RUN.

// One micro-rotation; in vectoring mode it picks its own direction from x,y.
module gr_cordic_urot #(
    parameter int R_LEN = 12,
    parameter int KW    = 4
) (
    input  logic signed [R_LEN-1:0] x_i,
    input  logic signed [R_LEN-1:0] y_i,
    input  logic [KW-1:0]           sh_i,
    input  logic                    vec_i,
    input  logic [1:0]              dir_i,
    output logic signed [R_LEN-1:0] x_o,
    output logic signed [R_LEN-1:0] y_o,
    output logic [1:0]              d_o
);
    logic signed [R_LEN-1:0] xs, ys;

    assign xs = x_i >>> sh_i;
    assign ys = y_i >>> sh_i;

    always_comb begin
        d_o = dir_i;
        if (vec_i) begin
            if (y_i == '0)                        d_o = 2'd2;
            else if (x_i[R_LEN-1] == y_i[R_LEN-1]) d_o = 2'd0;
            else                                  d_o = 2'd1;
        end
        x_o = x_i;
        y_o = y_i;
        case (d_o)
            2'd2: ;
            2'd1: begin
                x_o = x_i - ys;
                y_o = y_i + xs;
            end
            default: begin
                x_o = x_i + ys;
                y_o = y_i - xs;
            end
        endcase
    end
endmodule

module gr_cordic_engine #(
    parameter int R_LEN        = 12,
    parameter int R_FRAC       = 2,
    parameter int N_ITER       = 12,
    parameter int ITER_PER_CYC = 4
) (
    input logic        clk,
    input logic        rst,
    gr_cordic_if.slave bus
);
    localparam int NCYC  = N_ITER / ITER_PER_CYC;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int KW    = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [N_ITER-1:0][1:0] ALL_NOP = {N_ITER{2'b10}};

    if (N_ITER % ITER_PER_CYC != 0) begin : g_chk_iter
        $error("N_ITER must be a multiple of ITER_PER_CYC");
    end
    if (R_FRAC < 0 || R_FRAC >= R_LEN) begin : g_chk_frac
        $error("R_FRAC out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
`ifdef GR_SCALE_COMP_EN
        S_SCALE = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [R_LEN-1:0]  x_q, x_d, y_q, y_d;
    logic [N_ITER-1:0][1:0]   dir_q, dir_d;
    logic                     neg_q, neg_d;
    logic                     vec_q, vec_d;
    logic                     in_ready, load;

`ifdef GR_SCALE_COMP_EN
    // K ~ 0.6074 approximated by 2^-1 + 2^-3 - 2^-6 - 2^-9
    function automatic logic signed [R_LEN-1:0] kscale(input logic signed [R_LEN-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction
`endif

    // Unrolled chain; stage j handles global iteration cnt_q*ITER_PER_CYC + j
    logic signed [R_LEN-1:0] xc [ITER_PER_CYC+1];
    logic signed [R_LEN-1:0] yc [ITER_PER_CYC+1];
    logic [1:0]              dc [ITER_PER_CYC];
    logic [KW-1:0]           kc [ITER_PER_CYC];

    assign xc[0] = x_q;
    assign yc[0] = y_q;

    for (genvar j = 0; j < ITER_PER_CYC; j++) begin : g_rot
        assign kc[j] = KW'(int'(cnt_q) * ITER_PER_CYC + j);
        gr_cordic_urot #(.R_LEN(R_LEN), .KW(KW)) u_rot (
            .x_i   (xc[j]),
            .y_i   (yc[j]),
            .sh_i  (kc[j]),
            .vec_i (vec_q),
            .dir_i (dir_q[kc[j]]),
            .x_o   (xc[j+1]),
            .y_o   (yc[j+1]),
            .d_o   (dc[j])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        neg_d    = neg_q;
        vec_d    = vec_q;
        load     = 1'b0;
        in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);

        case (state_q)
            S_IDLE: load = bus.in_valid;
            S_RUN: begin
                x_d   = xc[ITER_PER_CYC];
                y_d   = yc[ITER_PER_CYC];
                cnt_d = cnt_q + CNT_W'(1);
                for (int j = 0; j < ITER_PER_CYC; j++) dir_d[kc[j]] = dc[j];
                if (cnt_q == CNT_W'(NCYC - 1)) begin
                    cnt_d = '0;
`ifdef GR_SCALE_COMP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef GR_SCALE_COMP_EN
            S_SCALE: begin
                x_d     = kscale(x_q);
                y_d     = kscale(y_q);
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    load    = bus.in_valid;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A release and a new accept in the same cycle fall through here too
        if (load) begin
            cnt_d = '0;
            if (bus.nop) begin
                x_d     = bus.xi;
                y_d     = bus.yi;
                dir_d   = ALL_NOP;
                neg_d   = 1'b0;
                vec_d   = 1'b0;
                state_d = S_DONE;
            end else begin
                neg_d   = bus.mode ? bus.xi[R_LEN-1] : bus.neg_i;
                x_d     = neg_d ? -bus.xi : bus.xi;
                y_d     = neg_d ? -bus.yi : bus.yi;
                dir_d   = bus.mode ? ALL_NOP : bus.dir_i;
                vec_d   = bus.mode;
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
            neg_q   <= 1'b0;
            vec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            neg_q   <= neg_d;
            vec_q   <= vec_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.xo        = x_q;
    assign bus.yo        = y_q;
    assign bus.dir_o     = dir_q;
    assign bus.neg_o     = neg_q;
endmodule
